// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P,
        GNT_D,
        GNT_I
    } arb_gnt_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority grant select: prog > data > fetch, except that a starved
// fetch jumps ahead of data (never ahead of the loader).
import mem_arb_pkg::*;

module arb_prio_sel (
    input  logic     p_req,
    input  logic     d_req,
    input  logic     i_req,
    input  logic     starve,
    output arb_gnt_t gnt
);

    // Pick the single winner for this IDLE cycle.
    always_comb begin
        gnt = GNT_NONE;
        if (p_req) begin
            gnt = GNT_P;
        end else if (i_req && starve) begin
            gnt = GNT_I;
        end else if (d_req) begin
            gnt = GNT_D;
        end else if (i_req) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences prog-loader, data and fetch accesses onto one single-ported
// BRAM, one transaction at a time, with 1-cycle acks and a pipeline hold.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                p_req,
    input  logic [ADDR_W-1:0]   p_addr,
    input  logic [DATA_W-1:0]   p_din,
    output logic                p_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_din,
    output logic [DATA_W-1:0]   d_dout,
    output logic                d_ack,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_dout,
    output logic                i_ack,
    output logic                m_en,
    output logic [DATA_W/8-1:0] m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_din,
    input  logic [DATA_W-1:0]   m_dout,
    output logic                mem_hold
);

    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int STRK_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_gnt_t          gnt, gnt_q;
    logic [CNT_W-1:0]  wait_q;
    logic [STRK_W-1:0] streak_q;
    logic              starve;
    logic              is_read;

    assign starve  = (streak_q == STRK_W'(STARVE_MAX));
    assign is_read = (gnt == GNT_I) || ((gnt == GNT_D) && !d_we);

    arb_prio_sel u_prio_sel (
        .p_req  (p_req),
        .d_req  (d_req),
        .i_req  (i_req),
        .starve (starve),
        .gnt    (gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (Rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    // Latch the winner and load the read-latency countdown at issue.
    always_ff @(posedge clk) begin
        if (Rst) begin
            gnt_q  <= GNT_NONE;
            wait_q <= '0;
        end else if (state_q == ARB_IDLE && gnt != GNT_NONE) begin
            gnt_q  <= gnt;
            wait_q <= CNT_W'(RD_LAT - 1);
        end else if (state_q == ARB_WAIT && wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
        end
    end

    // Consecutive-data-grant streak; clearing wins so it only counts while a fetch waits.
    always_ff @(posedge clk) begin
        if (Rst) begin
            streak_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (gnt == GNT_I || !i_req) begin
                streak_q <= '0;
            end else if (gnt == GNT_D && !starve) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

    // Capture read data on the last WAIT cycle into the owner's result register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            d_dout <= '0;
            i_dout <= '0;
        end else if (state_q == ARB_WAIT && wait_q == '0) begin
            if (gnt_q == GNT_D) d_dout <= m_dout;
            if (gnt_q == GNT_I) i_dout <= m_dout;
        end
    end

    // Next state, memory issue strobe/bus and ack pulses; all forced low in reset.
    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        m_we    = '0;
        m_addr  = '0;
        m_din   = '0;
        p_ack   = 1'b0;
        d_ack   = 1'b0;
        i_ack   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt != GNT_NONE) begin
                    m_en    = 1'b1;
                    state_d = is_read ? ARB_WAIT : ARB_DONE;
                    case (gnt)
                        GNT_P: begin
                            m_we   = '1;
                            m_addr = p_addr;
                            m_din  = p_din;
                        end
                        GNT_D: begin
                            m_we   = d_we ? d_be : '0;
                            m_addr = d_addr;
                            m_din  = d_din;
                        end
                        GNT_I: begin
                            m_addr = i_addr;
                        end
                        default: ;
                    endcase
                end
            end
            ARB_WAIT: begin
                if (wait_q == '0) state_d = ARB_DONE;
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                p_ack   = (gnt_q == GNT_P);
                d_ack   = (gnt_q == GNT_D);
                i_ack   = (gnt_q == GNT_I);
            end
            default: state_d = ARB_IDLE;
        endcase
        if (Rst) begin
            m_en   = 1'b0;
            m_we   = '0;
            m_addr = '0;
            m_din  = '0;
            p_ack  = 1'b0;
            d_ack  = 1'b0;
            i_ack  = 1'b0;
        end
    end

    // Stall while any core request is still unacknowledged.
    always_comb begin
        mem_hold = 1'b0;
        if (!Rst) mem_hold = (d_req & ~d_ack) | (i_req & ~i_ack) | p_req;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a BRAM model and issue/ack scoreboards.
import mem_arb_pkg::*;

module tb_mem_port_arbiter;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        Rst;
    logic        p_req, d_req, d_we, i_req;
    logic [31:0] p_addr, p_din, d_addr, d_din, i_addr;
    logic [3:0]  d_be;
    logic        p_ack, d_ack, i_ack, m_en, mem_hold;
    logic [31:0] d_dout, i_dout, m_addr, m_din, m_dout;
    logic [3:0]  m_we;
    logic        mem_clr;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .p_req    (p_req),
        .p_addr   (p_addr),
        .p_din    (p_din),
        .p_ack    (p_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_din    (d_din),
        .d_dout   (d_dout),
        .d_ack    (d_ack),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_dout   (i_dout),
        .i_ack    (i_ack),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_din    (m_din),
        .m_dout   (m_dout),
        .mem_hold (mem_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: read-first, RD_LAT=2 output pipeline.
    logic [31:0] bram [0:255];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) bram[k] <= '0;
        end else if (m_en) begin
            rd_p0 <= bram[m_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) bram[m_addr[9:2]][8*b +: 8] <= m_din[8*b +: 8];
        end
        rd_p1 <= rd_p0;
    end
    assign m_dout = rd_p1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } iss_t;
    typedef struct {
        arb_gnt_t    port;
        logic [31:0] data;
        int          lat;
        bit          rd;
    } ack_t;

    iss_t        iss_q[$];
    ack_t        ack_q[$];
    logic [31:0] ref_mem [0:255];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          outstanding = 0;
    int          issue_cyc = 0;
    iss_t        e_iss;
    ack_t        e_ack;
    arb_gnt_t    got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every issue and every ack against the queued expectations.
    always @(negedge clk) begin
        if (Rst) begin
            outstanding = 0;
        end else begin
            if (m_en) begin
                chk("issue_overlap", 64'(outstanding), 0);
                if (iss_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_issue: observed addr %0h expected no issue", m_addr);
                end else begin
                    e_iss = iss_q.pop_front();
                    chk("issue_addr", m_addr, e_iss.addr);
                    chk("issue_we", m_we, e_iss.we);
                    if (e_iss.we != 4'b0) chk("issue_din", m_din, e_iss.din);
                end
                outstanding = 1;
                issue_cyc   = cyc;
            end
            if (p_ack || d_ack || i_ack) begin
                got = p_ack ? GNT_P : (d_ack ? GNT_D : GNT_I);
                chk("ack_onehot", 64'($countones({p_ack, d_ack, i_ack})), 1);
                if (ack_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_ack: observed port %0d expected no ack", got);
                end else begin
                    e_ack = ack_q.pop_front();
                    chk("ack_port", got, e_ack.port);
                    chk("ack_latency", 64'(cyc - issue_cyc), 64'(e_ack.lat));
                    if (e_ack.rd) chk("ack_data", (got == GNT_D) ? d_dout : i_dout, e_ack.data);
                end
                outstanding = 0;
            end
        end
    end

    task automatic req_p(input logic [31:0] addr, input logic [31:0] data);
        iss_q.push_back('{addr, 4'hF, data});
        ack_q.push_back('{GNT_P, 32'h0, 1, 1'b0});
        ref_mem[addr[9:2]] = data;
        p_addr = addr;
        p_din  = data;
        p_req  = 1'b1;
    endtask

    task automatic req_d(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] din);
        iss_q.push_back('{addr, we ? be : 4'h0, din});
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = din[8*b +: 8];
            ack_q.push_back('{GNT_D, 32'h0, 1, 1'b0});
        end else begin
            ack_q.push_back('{GNT_D, ref_mem[addr[9:2]], RD_LAT + 1, 1'b1});
        end
        d_we   = we;
        d_be   = be;
        d_addr = addr;
        d_din  = din;
        d_req  = 1'b1;
    endtask

    task automatic req_i(input logic [31:0] addr, input bit expect_ack);
        iss_q.push_back('{addr, 4'h0, 32'h0});
        if (expect_ack) ack_q.push_back('{GNT_I, ref_mem[addr[9:2]], RD_LAT + 1, 1'b1});
        i_addr = addr;
        i_req  = 1'b1;
    endtask

    // Wait for every raised request to be acked, dropping each req after its ack.
    task automatic serve();
        bit pg = !p_req;
        bit dg = !d_req;
        bit ig = !i_req;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p_ack) pg = 1;
            if (d_ack) dg = 1;
            if (i_ack) ig = 1;
            step();
            if (pg) p_req = 1'b0;
            if (dg) d_req = 1'b0;
            if (ig) i_req = 1'b0;
            if (pg && dg && ig) return;
        end
        n_cmp++;
        n_err++;
        $error("FAIL serve_timeout: observed acks p%0d d%0d i%0d expected all", pg, dg, ig);
        p_req = 1'b0;
        d_req = 1'b0;
        i_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int ni;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        Rst = 1'b1; mem_clr = 1'b1;
        p_req = 1'b0; d_req = 1'b0; i_req = 1'b0; d_we = 1'b0; d_be = '0;
        p_addr = '0; p_din = '0; d_addr = '0; d_din = '0; i_addr = '0;

        // Reset with all requests high: everything quiet, state IDLE.
        req_p(32'h000, 32'h1111_1111);
        req_d(1'b0, 4'h0, 32'h000, 32'h0);
        req_i(32'h000, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_en", 64'(m_en), 0);
        chk("rst_m_we_addr", {m_we, m_addr}, 0);
        chk("rst_m_din", m_din, 0);
        chk("rst_acks_hold", {p_ack, d_ack, i_ack, mem_hold}, 0);
        chk("rst_d_dout", d_dout, 0);
        chk("rst_i_dout", i_dout, 0);
        chk("rst_state", dut.state_q, ARB_IDLE);

        // Release reset with p/d/i pending: served p, d, i in order.
        step();
        Rst = 1'b0; mem_clr = 1'b0;
        serve();
        repeat (2) step();

        // Data partial write; issue and ack timing checked inline.
        req_d(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("dw_m_en", 64'(m_en), 1);
        chk("dw_m_we", m_we, 4'b0011);
        @(negedge clk);
        chk("dw_d_ack", 64'(d_ack), 1);
        step();
        d_req = 1'b0;
        step();
        req_d(1'b0, 4'h0, 32'h100, 32'h0);
        serve();
        chk("dr_held", d_dout, 32'h0000_BEEF);

        // Write with no byte enables: acked as a write, memory and d_dout unchanged.
        step();
        req_d(1'b1, 4'b0000, 32'h100, 32'hFFFF_FFFF);
        serve();
        chk("be0_d_dout", d_dout, 32'h0000_BEEF);
        step();
        req_d(1'b0, 4'h0, 32'h100, 32'h0);
        serve();

        // Fetch read: hold for three cycles, ack on the fourth.
        step();
        req_p(32'h204, 32'hCAFE_F00D);
        serve();
        step();
        req_i(32'h204, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fetch_hold", 64'(mem_hold), 1);
        end
        @(negedge clk);
        chk("fetch_ack", 64'(i_ack), 1);
        chk("fetch_hold_ack", 64'(mem_hold), 0);
        chk("fetch_dout", i_dout, 32'hCAFE_F00D);
        step();
        i_req = 1'b0;
        repeat (2) step();

        // Starvation: d and i held high -> d,d,d,d,i,d,d,d,d,i.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < STARVE_MAX; k++) req_d(1'b1, 4'hF, 32'h180, 32'h5A5A_5A5A);
            req_i(32'h204, 1'b1);
        end
        ni = 0;
        for (int k = 0; k < 200 && ni < 2; k++) begin
            @(negedge clk);
            if (i_ack) ni++;
        end
        chk("starve_i_acks", 64'(ni), 2);
        step();
        d_req = 1'b0;
        i_req = 1'b0;
        repeat (2) step();

        // Reset during the WAIT of a fetch: the access is abandoned.
        req_i(32'h204, 1'b0);
        step();
        Rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        chk("rstw_m_en", 64'(m_en), 0);
        chk("rstw_acks", {p_ack, d_ack, i_ack, mem_hold}, 0);
        step();
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstw_no_ack", {m_en, i_ack}, 0);
        end
        chk("rstw_i_dout", i_dout, 0);
        step();
        req_d(1'b0, 4'h0, 32'h100, 32'h0);
        serve();
        chk("rstw_after", d_dout, 32'h0000_BEEF);

        repeat (3) step();
        chk("iss_q_drained", 64'(iss_q.size()), 0);
        chk("ack_q_drained", 64'(ack_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
